vga_sync_decoder: RTL and testbench

// Receive-side counterpart of the 640x480@60Hz sync generator. Samples external active-low

---
 rtl/vga_sync_decoder_if.sv | 23 ++
 rtl/vga_sync_decoder.sv | 162 ++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_sync_decoder_if.sv
// Sync-input / recovered-timing bundle for the VGA sync decoder.
// master = upstream source side, slave = decoder side.
interface vga_sync_decoder_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       lock_lost;

    modport master (
        output hsync_in, vsync_in,
        input  x, y, de, line_start, frame_start, locked, lock_lost
    );

    modport slave (
        input  hsync_in, vsync_in,
        output x, y, de, line_start, frame_start, locked, lock_lost
    );
endinterface

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and data-enable from external active-low hsync/vsync,
// and asserts lock only after a full frame of exactly-nominal timing.
module vga_sync_decoder #(
    parameter int H_TOTAL      = 800,
    parameter int H_ACTIVE     = 640,
    parameter int H_SYNC_START = 656,
    parameter int V_TOTAL      = 525,
    parameter int V_ACTIVE     = 480,
    parameter int V_SYNC_START = 490
) (
    input  logic              clk,
    input  logic              rst,
    vga_sync_decoder_if.slave bus
);

    typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

    state_t      state, state_nxt;
    logic        hs_p0, hs_p1, hs_p2;
    logic        vs_p0, vs_p1, vs_p2;
    logic        hfall, vfall;
    logic [9:0]  h_cnt, h_nxt, v_cnt, v_nxt;
    logic [10:0] per_cnt, per_nxt;
    logic [9:0]  line_cnt, line_nxt;
    logic        mismatch, mismatch_nxt;
    logic        first_h, first_h_nxt;
    logic        lost_set, lock_nxt, h_wrap, period_bad, timeout;
    logic [11:0] period;
    logic [9:0]  x_q, y_q;
    logic        de_q, line_start_q, frame_start_q, locked_q, lock_lost_q;

    // Stage p0/p1: two-flop synchroniser; p2: previous sample for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_p0 <= 1'b1;
            hs_p1 <= 1'b1;
            hs_p2 <= 1'b1;
            vs_p0 <= 1'b1;
            vs_p1 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p0 <= bus.hsync_in;
            hs_p1 <= hs_p0;
            hs_p2 <= hs_p1;
            vs_p0 <= bus.vsync_in;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
        end
    end

    assign hfall      = hs_p2 & ~hs_p1;
    assign vfall      = vs_p2 & ~vs_p1;
    assign h_wrap     = (h_cnt == 10'(H_TOTAL - 1));
    assign period     = {1'b0, per_cnt} + 12'd1;
    assign period_bad = (period != 12'(H_TOTAL));
    assign timeout    = (per_cnt >= 11'(2 * H_TOTAL));

    // An hfall landing on the wrap clock reloads h, so v does not advance then
    always_comb begin
        h_nxt = h_wrap ? 10'd0 : h_cnt + 10'd1;
        if (hfall)
            h_nxt = 10'(H_SYNC_START);

        v_nxt = v_cnt;
        if (vfall)
            v_nxt = 10'(V_SYNC_START);
        else if (h_wrap && !hfall)
            v_nxt = (v_cnt == 10'(V_TOTAL - 1)) ? 10'd0 : v_cnt + 10'd1;

        per_nxt = (per_cnt == 11'h7FF) ? per_cnt : per_cnt + 11'd1;
        if (hfall)
            per_nxt = 11'd0;

        line_nxt = line_cnt;
        if (vfall)
            line_nxt = 10'd0;
        else if (hfall && line_cnt != 10'h3FF)
            line_nxt = line_cnt + 10'd1;
    end

    always_comb begin
        state_nxt    = state;
        mismatch_nxt = mismatch;
        first_h_nxt  = first_h;
        lost_set     = 1'b0;
        case (state)
            HUNT: begin
                if (vfall) begin
                    state_nxt    = CHECK;
                    mismatch_nxt = 1'b0;
                    first_h_nxt  = 1'b1;
                end
            end
            CHECK: begin
                // The first hfall after entry has no trustworthy predecessor
                if (hfall) begin
                    if (first_h)
                        first_h_nxt = 1'b0;
                    else if (period_bad)
                        mismatch_nxt = 1'b1;
                end
                if (vfall) begin
                    if (line_cnt == 10'(V_TOTAL) && !mismatch)
                        state_nxt = LOCKED;
                    mismatch_nxt = 1'b0;
                end
            end
            LOCKED: begin
                if ((hfall && period_bad) || (vfall && line_cnt != 10'(V_TOTAL)) || timeout) begin
                    state_nxt = HUNT;
                    lost_set  = 1'b1;
                end
            end
            default: state_nxt = HUNT;
        endcase
    end

    assign lock_nxt = (state_nxt == LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= HUNT;
            h_cnt         <= '0;
            v_cnt         <= '0;
            per_cnt       <= '0;
            line_cnt      <= '0;
            mismatch      <= 1'b0;
            first_h       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            lock_lost_q   <= 1'b0;
        end else begin
            state         <= state_nxt;
            h_cnt         <= h_nxt;
            v_cnt         <= v_nxt;
            per_cnt       <= per_nxt;
            line_cnt      <= line_nxt;
            mismatch      <= mismatch_nxt;
            first_h       <= first_h_nxt;
            x_q           <= lock_nxt ? h_nxt : 10'd0;
            y_q           <= lock_nxt ? v_nxt : 10'd0;
            de_q          <= lock_nxt && (h_nxt < 10'(H_ACTIVE)) && (v_nxt < 10'(V_ACTIVE));
            line_start_q  <= lock_nxt && (h_nxt == 10'd0);
            frame_start_q <= lock_nxt && (h_nxt == 10'd0) && (v_nxt == 10'd0);
            locked_q      <= lock_nxt;
            lock_lost_q   <= lock_lost_q | lost_set;
        end
    end

    assign bus.x           = x_q;
    assign bus.y           = y_q;
    assign bus.de          = de_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.locked      = locked_q;
    assign bus.lock_lost   = lock_lost_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a shrunken raster: scenario table, randomized frames,
// and hand-written pulse-spacing / async-reset sequences, all against a timestamp model.
module tb_vga_sync_decoder;
    localparam int HT = 20, HA = 12, HSS = 14, HSW = 3;
    localparam int VT = 8,  VA = 5,  VSS = 6,  VSW = 1;
    localparam int MH = 0, MC = 1, ML = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    vga_sync_decoder_if bus();

    vga_sync_decoder #(
        .H_TOTAL(HT), .H_ACTIVE(HA), .H_SYNC_START(HSS),
        .V_TOTAL(VT), .V_ACTIVE(VA), .V_SYNC_START(VSS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // source generator state
    int sx = 0, sy = 0;
    int f_lines = VT, bad_line = -1, bad_delta = 0;
    bit src_hold = 1'b0;

    // reference model state: events are timestamped by clock-edge index m
    int m;
    bit hh[4], vh[4];
    int mst, last_h, h_anchor, h_base, eh, ey, lines;
    bit ok, skip, elost;

    // pulse spacing recorder
    bit rec = 1'b0;
    int ls_cnt, ls_last, ls_badint, fs_cnt, fs_last, fs_badint;

    typedef struct {
        int frames;
        int lines;
        int bline;
        int delta;
        bit hold;
        bit exp_locked;
        bit exp_lost;
    } scen_t;
    scen_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] act_pack();
        return {7'd0, bus.locked, bus.lock_lost, bus.de, bus.line_start, bus.frame_start,
                bus.x, bus.y};
    endfunction

    function automatic logic [31:0] exp_pack();
        bit lk, de, ls, fs;
        logic [9:0] ex, eyv;
        lk  = (mst == ML);
        de  = lk && eh < HA && ey < VA;
        ls  = lk && eh == 0;
        fs  = ls && ey == 0;
        ex  = lk ? 10'(eh) : 10'd0;
        eyv = lk ? 10'(ey) : 10'd0;
        return {7'd0, lk, elost, de, ls, fs, ex, eyv};
    endfunction

    task automatic model_reset();
        m = 0;
        for (int i = 0; i < 4; i++) begin
            hh[i] = 1'b1;
            vh[i] = 1'b1;
        end
        mst = MH; last_h = 0; h_anchor = 0; h_base = 0; eh = 0; ey = 0;
        lines = 0; ok = 1'b1; skip = 1'b0; elost = 1'b0;
    endtask

    // Edge m sees a falling edge of the input driven three clocks earlier
    task automatic model_step();
        bit hf, vf;
        int period, idle;
        hf     = hh[3] && !hh[2];
        vf     = vh[3] && !vh[2];
        period = m - last_h;
        idle   = m - 1 - last_h;
        case (mst)
            MH: if (vf) begin mst = MC; ok = 1'b1; skip = 1'b1; end
            MC: begin
                if (hf) begin
                    if (skip) skip = 1'b0;
                    else if (period != HT) ok = 1'b0;
                end
                if (vf) begin
                    if (lines == VT && ok) mst = ML;
                    ok = 1'b1;
                end
            end
            default: begin
                if ((hf && period != HT) || (vf && lines != VT) || idle >= 2 * HT) begin
                    mst   = MH;
                    elost = 1'b1;
                end
            end
        endcase
        if (vf) lines = 0;
        else if (hf) lines++;
        if (hf) begin
            last_h   = m;
            h_anchor = m;
            h_base   = HSS;
        end
        eh = (h_base + m - h_anchor) % HT;
        if (vf) ey = VSS;
        else if (eh == 0) ey = (ey + 1) % VT;
    endtask

    task automatic drive_src();
        bit hs, vs;
        int len;
        hs = src_hold ? 1'b1 : !(sx >= HSS && sx < HSS + HSW);
        vs = !(sy >= VSS && sy < VSS + VSW);
        bus.hsync_in = hs;
        bus.vsync_in = vs;
        for (int i = 3; i > 0; i--) begin
            hh[i] = hh[i-1];
            vh[i] = vh[i-1];
        end
        hh[0] = hs;
        vh[0] = vs;
        len = (sy == bad_line) ? HT + bad_delta : HT;
        if (sx == len - 1) begin
            sx = 0;
            sy = (sy == f_lines - 1) ? 0 : sy + 1;
        end else begin
            sx++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        m++;
        model_step();
        chk($sformatf("cycle%0d", m), act_pack(), exp_pack());
        if (rec) begin
            if (bus.line_start) begin
                if (ls_last >= 0 && m - ls_last != HT) ls_badint++;
                ls_cnt++;
                ls_last = m;
            end
            if (bus.frame_start) begin
                if (fs_last >= 0 && m - fs_last != HT * VT) fs_badint++;
                fs_cnt++;
                fs_last = m;
            end
        end
        drive_src();
    endtask

    task automatic release_rst();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        chk("reset_state", act_pack(), exp_pack());
        drive_src();
    endtask

    task automatic mid_rst();
        @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("async_rst_clear", act_pack(), 32'd0);
        release_rst();
    endtask

    task automatic run_frame(input int nl, input int bl, input int dl, input bit hold,
                             input bit do_rst);
        int total;
        bit pend;
        f_lines   = nl;
        bad_line  = bl;
        bad_delta = dl;
        src_hold  = hold;
        pend      = do_rst;
        total     = nl * HT + ((bl >= 0) ? dl : 0);
        for (int i = 0; i < total; i++) begin
            if (pend && sy == 3 && sx == 5) begin
                mid_rst();
                pend = 1'b0;
            end else begin
                tick();
            end
        end
        src_hold = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{2, VT,     -1, 0, 1'b0, 1'b1, 1'b0};  // clean start: lock after 2nd vfall
        tbl[1] = '{1, VT,      2, 1, 1'b0, 1'b0, 1'b1};  // one 21-clock line drops lock
        tbl[2] = '{1, VT,     -1, 0, 1'b0, 1'b1, 1'b1};  // relock, lock_lost sticky
        tbl[3] = '{1, VT,     -1, 0, 1'b1, 1'b0, 1'b1};  // hsync stuck high: timeout
        tbl[4] = '{1, VT - 1, -1, 0, 1'b0, 1'b0, 1'b1};  // short frame
        tbl[5] = '{1, VT,     -1, 0, 1'b0, 1'b0, 1'b1};  // CHECK window of VT-1 lines
        tbl[6] = '{1, VT,     -1, 0, 1'b0, 1'b1, 1'b1};  // full window: lock

        bus.hsync_in = 1'b1;
        bus.vsync_in = 1'b1;
        model_reset();
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("in_reset", act_pack(), 32'd0);
        release_rst();

        for (int s = 0; s < 7; s++) begin
            for (int f = 0; f < tbl[s].frames; f++)
                run_frame(tbl[s].lines, tbl[s].bline, tbl[s].delta, tbl[s].hold, 1'b0);
            chk($sformatf("scen%0d_locked", s), {31'd0, bus.locked}, {31'd0, tbl[s].exp_locked});
            chk($sformatf("scen%0d_lost", s), {31'd0, bus.lock_lost}, {31'd0, tbl[s].exp_lost});
        end

        for (int f = 0; f < 6; f++) begin
            case ($urandom_range(0, 4))
                0: run_frame(VT, -1, 0, 1'b0, 1'b0);
                1: run_frame(VT, $urandom_range(0, VT - 1), ($urandom_range(0, 1) != 0) ? 1 : -1,
                             1'b0, 1'b0);
                2: run_frame(VT - 1, -1, 0, 1'b0, 1'b0);
                3: run_frame(VT + 1, -1, 0, 1'b0, 1'b0);
                default: run_frame(VT, -1, 0, 1'b1, 1'b0);
            endcase
        end

        repeat (3) run_frame(VT, -1, 0, 1'b0, 1'b0);
        chk("relock_after_random", {31'd0, bus.locked}, 32'd1);

        ls_cnt = 0; ls_last = -1; ls_badint = 0;
        fs_cnt = 0; fs_last = -1; fs_badint = 0;
        rec = 1'b1;
        repeat (2) run_frame(VT, -1, 0, 1'b0, 1'b0);
        rec = 1'b0;
        chk("line_start_count", 32'(ls_cnt), 32'(2 * VT));
        chk("line_start_spacing", 32'(ls_badint), 32'd0);
        chk("frame_start_count", 32'(fs_cnt), 32'd2);
        chk("frame_start_spacing", 32'(fs_badint), 32'd0);

        chk("locked_before_rst", {31'd0, bus.locked}, 32'd1);
        run_frame(VT, -1, 0, 1'b0, 1'b1);
        chk("unlocked_after_rst", {31'd0, bus.locked}, 32'd0);
        run_frame(VT, -1, 0, 1'b0, 1'b0);
        chk("relock_after_rst", {31'd0, bus.locked}, 32'd1);
        chk("lost_cleared_by_rst", {31'd0, bus.lock_lost}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
